// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with TX queue and idle irq.
// Define UART_TX_FIFO_EN for a DEPTH-entry FIFO; otherwise a one-byte holding register.
module io_uart_tx #(
    parameter int BAUD_DIV = 87,
    parameter int DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_sel,
    input  logic [7:0]  io_word_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] io_rdata,
    output logic        tx,
    output logic        irq
);

    localparam logic [7:0]  ADDR_DATA   = 8'h01;
    localparam logic [7:0]  ADDR_STATUS = 8'h02;
    localparam logic [15:0] RELOAD      = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        overflow;

    logic        wr_cyc;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        stat_wr;
    logic        rd_req;
    logic        empty;
    logic        full;
    logic        busy;
    logic [7:0]  head;
    logic        unused;

    assign wr_cyc   = io_sel && (mem_wmask != 4'b0000);
    assign push_req = io_sel && mem_wmask[0] && (io_word_address == ADDR_DATA);
    assign stat_wr  = wr_cyc && (io_word_address == ADDR_STATUS);
    assign rd_req   = io_sel && mem_rstrb;

    // A pop on the same edge frees a slot, so a push into a full queue still lands.
    assign pop  = (state == IDLE) && !empty;
    assign push = push_req && (!full || pop);

    assign busy   = !empty || (state != IDLE);
    assign irq    = !busy;
    assign unused = ^mem_wdata[31:8];

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end
`else
    localparam int unused_depth = DEPTH;

    logic       hold_valid;
    logic [7:0] hold_data;

    assign empty = !hold_valid;
    assign full  = hold_valid;
    assign head  = hold_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= mem_wdata[7:0];
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // A dropped byte on the clearing edge keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_req && !push) begin
            overflow <= 1'b1;
        end else if (stat_wr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_rdata <= 32'h0;
        end else if (rd_req) begin
            if (io_word_address == ADDR_STATUS) begin
                io_rdata <= {29'b0, overflow, full, busy};
            end else begin
                io_rdata <= 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            timer   <= 16'h0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift <= head;
                        timer <= RELOAD;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (timer == 16'h0) begin
                        tx      <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= 3'd0;
                        timer   <= RELOAD;
                        state   <= DATA;
                    end else begin
                        timer <= timer - 16'h1;
                    end
                end
                DATA: begin
                    if (timer == 16'h0) begin
                        timer <= RELOAD;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'h1;
                    end
                end
                STOP: begin
                    if (timer == 16'h0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'h1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed checks of io_uart_tx framing, queueing, status and reset.
// Runs with BAUD_DIV=4, DEPTH=8; expectations follow UART_TX_FIFO_EN when defined.
module tb_io_uart_tx;

    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_sel = 1'b0;
    logic [7:0]  io_word_address = 8'h00;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wmask = 4'h0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] io_rdata;
    logic        tx;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    io_uart_tx #(
        .BAUD_DIV(BD),
        .DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_sel(io_sel),
        .io_word_address(io_word_address),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb),
        .io_rdata(io_rdata),
        .tx(tx),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] m = 4'b0001, input logic sel = 1'b1);
        @(negedge clk);
        io_sel          = sel;
        io_word_address = a;
        mem_wdata       = d;
        mem_wmask       = m;
        @(posedge clk);
        #1;
        io_sel    = 1'b0;
        mem_wmask = 4'h0;
    endtask

    task automatic rd(input logic [7:0] a);
        @(negedge clk);
        io_sel          = 1'b1;
        io_word_address = a;
        mem_rstrb       = 1'b1;
        @(posedge clk);
        #1;
        io_sel    = 1'b0;
        mem_rstrb = 1'b0;
    endtask

    // Called just after the edge that starts a frame; ends one edge past the stop bit.
    task automatic frame(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < BD; j++) begin
                chk(tag, {31'b0, tx}, {31'b0, bits[k]});
                if (k == 9 && j == BD - 1) begin
                    chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
                end
                step(1);
            end
        end
    endtask

    initial begin
        #12;
        chk("rst_tx", {31'b0, tx}, 32'h1);
        chk("rst_irq", {31'b0, irq}, 32'h1);
        chk("rst_rdata", io_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(2);
        chk("idle_tx", {31'b0, tx}, 32'h1);

        wr(8'h01, 32'h12, 4'b0010);
        wr(8'h01, 32'h34, 4'b0001, 1'b0);
        wr(8'h03, 32'h56);
        step(2);
        chk("ign_irq", {31'b0, irq}, 32'h1);
        chk("ign_tx", {31'b0, tx}, 32'h1);
        rd(8'h02);
        chk("ign_stat", io_rdata, 32'h0);

        wr(8'h01, 32'h55);
        chk("w55_tx", {31'b0, tx}, 32'h1);
        chk("w55_irq", {31'b0, irq}, 32'h0);
        step(1);
        chk("w55_fall", {31'b0, tx}, 32'h0);
        frame("f55", 8'h55);
        chk("f55_done_irq", {31'b0, irq}, 32'h1);
        chk("f55_done_tx", {31'b0, tx}, 32'h1);

        wr(8'h01, 32'hA3);
        wr(8'h01, 32'h3C);
        chk("a3_fall", {31'b0, tx}, 32'h0);
        frame("fA3", 8'hA3);
        chk("gap_tx", {31'b0, tx}, 32'h1);
        chk("gap_irq", {31'b0, irq}, 32'h0);
        step(1);
        chk("3c_fall", {31'b0, tx}, 32'h0);
        frame("f3C", 8'h3C);
        chk("b2b_irq", {31'b0, irq}, 32'h1);

        for (int i = 0; i < 10; i++) begin
            wr(8'h01, 32'h10 + 32'(i));
        end
        rd(8'h02);
        chk("ovf_stat", io_rdata, 32'h7);
        chk("ovf_irq", {31'b0, irq}, 32'h0);
        step(1);
        chk("rdata_hold", io_rdata, 32'h7);
        rd(8'h05);
        chk("unmapped", io_rdata, 32'h0);
        wr(8'h02, 32'h0, 4'b1000);
        rd(8'h02);
        chk("ovf_clr", io_rdata, 32'h3);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_tx", {31'b0, tx}, 32'h1);
        chk("rst2_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        rd(8'h02);
        chk("rst2_stat", io_rdata, 32'h0);

        wr(8'h01, 32'h00);
        wr(8'h01, 32'h81);
        step(17);
        chk("bit3_tx", {31'b0, tx}, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", {31'b0, tx}, 32'h1);
        chk("mid_rst_irq", {31'b0, irq}, 32'h1);
        chk("mid_rst_rdata", io_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd(8'h02);
        chk("mid_rst_stat", io_rdata, 32'h0);
        step(3);
        chk("discard_tx", {31'b0, tx}, 32'h1);
        chk("discard_irq", {31'b0, irq}, 32'h1);
        wr(8'h01, 32'hC4);
        step(1);
        chk("c4_fall", {31'b0, tx}, 32'h0);
        frame("fC4", 8'hC4);
        chk("c4_irq", {31'b0, irq}, 32'h1);

        wr(8'h01, 32'h11);
        step(5);
        wr(8'h01, 32'h22);
        wr(8'h01, 32'h33);
        rd(8'h02);
`ifdef UART_TX_FIFO_EN
        chk("q2_stat", io_rdata, 32'h1);
`else
        chk("hold_ovf", io_rdata, 32'h7);
`endif
        wr(8'h02, 32'h0);
        rd(8'h02);
`ifdef UART_TX_FIFO_EN
        chk("q2_clr", io_rdata, 32'h1);
`else
        chk("hold_clr", io_rdata, 32'h3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
